ks_nibble_seq_adder: RTL and testbench
======================================

Name: ks_nibble_seq_adder

Overview:
- Sequencer that performs a WIDTH-bit addition by streaming 4-bit slices, LSB first, through an external 4-bit Kogge-Stone adder.
- Captures operands on a valid/ready input handshake and drives the adder's a/b/cin each cycle.
- Latches the returned sum nibble and carry into a result register, then presents the full sum on a valid/ready output handshake.
- Sits directly upstream of the 4-bit adder (feeds it) and also consumes its outputs.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of 4-bit slices; derived, do not override.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- add_a  output  4  slice of A to adder.
- add_b  output  4  slice of B to adder.
- add_cin  output  1  carry to adder.
- add_sum  input  4  adder sum (combinational, same cycle).
- add_cout  input  1  adder carry-out (combinational, same cycle).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  full sum.
- out_cout  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (async, any time, including mid-operation): FSM returns to IDLE and the operation is aborted with no output.
  - All registers clear: A/B registers, carry, slice index, result.
  - Output values in reset: out_valid=0, out_sum=0, out_cout=0, busy=0, in_ready=1.
  - add_a/add_b/add_cin are 0 while in reset.
- IDLE:
  - in_ready=1; add_* driven 0.
  - On in_valid&&in_ready: capture in_a, in_b, in_cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Adder drive: add_a=a_reg[4*idx+3:4*idx], add_b likewise from b_reg, add_cin=carry_reg (carry_reg holds captured in_cin at idx 0).
  - Each clock edge: result[4*idx+3:4*idx]<=add_sum; carry_reg<=add_cout; idx<=idx+1.
  - After the edge that processes idx=NSLICE-1: out_cout<=add_cout; go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout hold stable until out_valid&&out_ready.
  - On that handshake: go to IDLE, out_valid drops the next cycle.
  - out_sum/out_cout retain their last value afterwards.
  - in_ready=0 in DONE; no input is accepted in the same cycle the output handshakes.
- Latency and throughput:
  - out_valid rises exactly NSLICE cycles after the input handshake edge.
  - One operation per NSLICE+2 cycles with out_ready tied 1.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1).
- in_* changes while not in IDLE are ignored.
- in_valid during reset is ignored.
- idx width is clog2(NSLICE); idx never exceeds NSLICE-1.

Optional Feature:
- Macro: KS_NIBBLE_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port out_ovf (1 bit), the signed two's-complement overflow flag.
  - Computed at the last slice as (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (add_sum[3]!=a_reg[WIDTH-1]).
  - Registered alongside out_cout; 0 on reset; valid while out_valid=1.
- Undefined: port absent; no other behaviour changes.

Test Plan:
- WIDTH=16; in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1, out_valid exactly 4 cycles after the accept edge; add_cin seen as 0,1,1,1 across slices.
- in_a=0x1234, in_b=0x4321, in_cin=1 -> out_sum=0x5556, out_cout=0.
- Hold out_ready=0 for 5 cycles after result 0x1111+0x2222=0x3333 -> out_valid and out_sum stay stable; in_ready=0 throughout; handshake then returns to IDLE.
- Assert rst_n=0 asynchronously mid-RUN (idx=2) -> out_valid=0, in_ready=1, busy=0 immediately; the next op 0x0003+0x0004 yields 0x0007.
- Back-to-back ops with out_ready=1 and in_valid=1 -> in_ready pulses once every 6 cycles; results are correct in order.
- With KS_NIBBLE_SEQ_OVERFLOW_EN: 0x7FFF+0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0; 0xFFFF+0x0001 -> out_ovf=0.

Source files
------------

// File: rtl/ks_nibble_seq_adder_if.sv
//==============================================================================
// Module   : ks_nibble_seq_adder_if
// Purpose  : Operand/result handshakes and 4-bit adder bus of the nibble adder.
//            Optional macro: KS_NIBBLE_SEQ_OVERFLOW_EN (adds out_ovf).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface ks_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
    logic             out_ovf;
`endif

    // The sequencer side: consumes operands and adder results, produces the sum.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
        , output out_ovf
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
        , input out_ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/ks_nibble_seq_adder.sv
//==============================================================================
// Module   : ks_nibble_seq_adder
// Purpose  : WIDTH-bit adder built by streaming 4-bit slices, LSB first,
//            through an external 4-bit Kogge-Stone adder.
//            Optional macro: KS_NIBBLE_SEQ_OVERFLOW_EN (signed overflow flag).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module ks_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input wire                    clk,
    input wire                    rst_n,
    ks_nibble_seq_adder_if.slave  bus
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic             in_ready_w;
    logic             out_valid_w;
    logic             busy_w;
    logic [3:0]       add_a_w;
    logic [3:0]       add_b_w;
    logic             add_cin_w;
    logic             last_slice_w;

    logic [3:0] a_slice [NSLICE];
    logic [3:0] b_slice [NSLICE];

    generate
        for (genvar g = 0; g < NSLICE; g++) begin : g_slice
            assign a_slice[g] = a_q[4*g +: 4];
            assign b_slice[g] = b_q[4*g +: 4];
        end
    endgenerate

    assign last_slice_w = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        idx_d       = idx_q;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        busy_w      = 1'b0;
        add_a_w     = 4'h0;
        add_b_w     = 4'h0;
        add_cin_w   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy_w    = 1'b1;
                add_a_w   = a_slice[idx_q];
                add_b_w   = b_slice[idx_q];
                add_cin_w = carry_q;
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[4*i +: 4] = bus.add_sum;
                    end
                end
                carry_d = bus.add_cout;
                if (last_slice_w) begin
                    cout_d  = bus.add_cout;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
                    // Same-sign operands whose sum flips sign have overflowed.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (bus.add_sum[3] != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                busy_w      = 1'b1;
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.busy      = busy_w;
    assign bus.add_a     = add_a_w;
    assign bus.add_b     = add_b_w;
    assign bus.add_cin   = add_cin_w;
    assign bus.out_sum   = result_q;
    assign bus.out_cout  = cout_q;
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
    assign bus.out_ovf   = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ks_nibble_seq_adder.sv
//==============================================================================
// Module   : tb_ks_nibble_seq_adder
// Purpose  : Directed self-checking bench for ks_nibble_seq_adder (WIDTH=16).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ks_nibble_seq_adder;

    localparam int W   = 16;
    localparam int NSL = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ks_nibble_seq_adder_if #(.WIDTH(W)) bus ();

    ks_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the external 4-bit adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'h0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag, input int stall);
        int         w;
        int         lat;
        int         ns;
        logic       c;
        logic [4:0] t;
        logic       cin_seen [NSL];
        logic       cin_exp  [NSL];

        c = v.cin;
        for (int s = 0; s < NSL; s++) begin
            cin_exp[s]  = c;
            cin_seen[s] = 1'bx;
            t = {1'b0, v.a[4*s +: 4]} + {1'b0, v.b[4*s +: 4]} + {4'h0, c};
            c = t[4];
        end

        @(negedge clk);
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_cin    = v.cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);

        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scrambled inputs must not disturb an operation already captured.
        bus.in_a     = ~v.a;
        bus.in_b     = ~v.b;
        bus.in_cin   = ~v.cin;
        lat = 0;
        ns  = 0;
        while (!bus.out_valid && lat < 20) begin
            if (ns < NSL) cin_seen[ns] = bus.add_cin;
            ns++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(NSL));
        check({tag, " out_sum"}, 32'(bus.out_sum), 32'(v.exp_sum));
        check({tag, " out_cout"}, 32'(bus.out_cout), 32'(v.exp_cout));
`ifdef KS_NIBBLE_SEQ_OVERFLOW_EN
        check({tag, " out_ovf"}, 32'(bus.out_ovf), 32'(v.exp_ovf));
`endif
        for (int s = 0; s < NSL; s++) begin
            check($sformatf("%s add_cin slice%0d", tag, s), 32'(cin_seen[s]), 32'(cin_exp[s]));
        end

        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s stall%0d out_valid", tag, k), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s stall%0d out_sum", tag, k), 32'(bus.out_sum), 32'(v.exp_sum));
            check($sformatf("%s stall%0d in_ready", tag, k), 32'(bus.in_ready), 32'd0);
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
        check({tag, " out_sum retained"}, 32'(bus.out_sum), 32'(v.exp_sum));
        bus.out_ready = 1'b0;
    endtask

    vec_t vecs [8];
    vec_t v;
    vec_t b2b [3];

    initial begin
        int k;
        int j;
        int last;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        b2b[0] = '{16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0};
        b2b[1] = '{16'hFFF0, 16'h0020, 1'b0, 16'h0010, 1'b1, 1'b0};
        b2b[2] = '{16'h8888, 16'h8888, 1'b1, 16'h1111, 1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h1234;
        bus.in_b      = 16'h1111;
        bus.in_cin    = 1'b1;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset out_sum", 32'(bus.out_sum), 32'd0);
        check("reset out_cout", 32'(bus.out_cout), 32'd0);
        check("reset add_a", 32'(bus.add_a), 32'd0);
        check("reset add_cin", 32'(bus.add_cin), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i), 0);
        end

        v = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
        run_op(v, "stall", 5);

        // Abort an operation asynchronously while slice 2 is on the adder.
        @(negedge clk);
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h0000;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrun add_a slice2", 32'(bus.add_a), 32'h2);
        check("midrun busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset in_ready", 32'(bus.in_ready), 32'd1);
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset add_a", 32'(bus.add_a), 32'd0);
        check("async reset out_sum", 32'(bus.out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        run_op(v, "after reset", 0);

        // Back-to-back stream with out_ready tied high.
        bus.out_ready = 1'b1;
        k    = 0;
        j    = 0;
        last = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check($sformatf("b2b%0d out_sum", j), 32'(bus.out_sum), 32'(b2b[j].exp_sum));
                check($sformatf("b2b%0d out_cout", j), 32'(bus.out_cout), 32'(b2b[j].exp_cout));
                j++;
            end
            if (bus.in_ready) begin
                if (last >= 0) check("b2b in_ready spacing", 32'(cyc - last), 32'd6);
                last = cyc;
                if (k < 3) begin
                    bus.in_a     = b2b[k].a;
                    bus.in_b     = b2b[k].b;
                    bus.in_cin   = b2b[k].cin;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
                k++;
            end
            if (j == 3) break;
        end
        bus.in_valid = 1'b0;
        check("b2b results seen", 32'(j), 32'd3);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("b2b final in_ready", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
